// File: rtl/serial_adder_nbit_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state codes and default width.
package serial_adder_nbit_pkg;

   localparam int unsigned DEF_WIDTH = 4;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_RUN  = 2'd1;
   localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/full_adder_1bit.sv
// Single combinational full adder cell, time-multiplexed across bits by the serial adder.
module full_adder_1bit (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic s,
   output logic c_out
);

   assign s     = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder_nbit.sv
// Bit-serial N-bit adder: operands in via valid/ready, LSB-first summation one bit per clock,
// result (sum, carry-out, signed overflow) held under valid/ready until consumed.
module serial_adder_nbit
   import serial_adder_nbit_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             V
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic fa_s;
   logic fa_co;

   full_adder_1bit u_fa (
      .a     (a_sr[0]),
      .b     (b_sr[0]),
      .c_in  (carry),
      .s     (fa_s),
      .c_out (fa_co)
   );

   // FSM, bit counter, shift registers and registered outputs.
   // Sum bits fill a_sr from the top as augend bits leave the bottom, so after WIDTH
   // shifts a_sr holds the sum; the final edge merges the last bit straight into s.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         a_sr      <= '0;
         b_sr      <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         s         <= '0;
         c_out     <= 1'b0;
         V         <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_sr     <= a;
                  b_sr     <= b;
                  carry    <= c_in;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= S_RUN;
               end
            end
            S_RUN: begin
               a_sr  <= {fa_s, a_sr[WIDTH-1:1]};
               b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
               carry <= fa_co;
               if (cnt == CNT_LAST) begin
                  cnt       <= '0;
                  s         <= {fa_s, a_sr[WIDTH-1:1]};
                  c_out     <= fa_co;
                  V         <= carry ^ fa_co;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               cnt       <= '0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Scoreboard bench for serial_adder_nbit (WIDTH=4): directed vectors plus an operand sweep.
module tb_serial_adder_nbit;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic         c_out;
   logic         v;

   logic rdy_rand;
   logic rdy_force;
   logic rnd_bit;

   int errors = 0;
   int checks = 0;
   logic [5:0] exp_q[$];

   assign out_ready = rdy_rand ? rnd_bit : rdy_force;

   serial_adder_nbit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .c_out     (c_out),
      .V         (v)
   );

   always #5 clk = ~clk;

   // Random consumer readiness, changed just after each rising edge.
   initial begin
      rnd_bit = 1'b0;
      forever begin
         @(posedge clk);
         #1 rnd_bit = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: every accepted result is checked against the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL result_unexpected: got s=%h c_out=%b V=%b with nothing expected",
                     s, c_out, v);
         end else begin
            logic [5:0] want;
            want = exp_q.pop_front();
            if ({s, c_out, v} !== want) begin
               errors = errors + 1;
               $display("FAIL result: got s=%h c_out=%b V=%b want s=%h c_out=%b V=%b",
                        s, c_out, v, want[5:2], want[1], want[0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks = checks + 1;
      if (got !== want) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   function automatic logic [5:0] model(input logic [3:0] x, input logic [3:0] y, input logic c);
      logic [4:0] sum;
      logic       ovf;
      sum = {1'b0, x} + {1'b0, y} + {4'b0, c};
      ovf = (x[3] == y[3]) && (sum[3] != x[3]);
      return {sum[3:0], sum[4], ovf};
   endfunction

   // Offer operands, wait (bounded) for acceptance, then scramble the inputs.
   task automatic send(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                       input bit push, input logic [5:0] want);
      int n;
      in_valid = 1'b1;
      a = ta;
      b = tb;
      c_in = tc;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 100);
      chk("accept", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 4'($urandom);
      b = 4'($urandom);
      c_in = 1'($urandom);
      if (push) exp_q.push_back(want);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   initial begin
      int n;
      bit seen;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      c_in = 1'b0;
      rdy_rand = 1'b0;
      rdy_force = 1'b1;

      // 1. reset values
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_s", {28'b0, s}, 32'd0);
      chk("rst_c_out", {31'b0, c_out}, 32'd0);
      chk("rst_v", {31'b0, v}, 32'd0);

      // 2. 7+1 and latency
      send(4'd7, 4'd1, 1'b0, 1'b1, {4'b1000, 1'b0, 1'b1});
      wait_valid(n);
      chk("latency", n, 32'd4);
      @(posedge clk);
      #1;
      chk("t2_out_valid_drop", {31'b0, out_valid}, 32'd0);
      chk("t2_in_ready_back", {31'b0, in_ready}, 32'd1);

      // 3. 15+1 under backpressure
      rdy_force = 1'b0;
      send(4'd15, 4'd1, 1'b0, 1'b1, {4'h0, 1'b1, 1'b0});
      wait_valid(n);
      chk("t3_valid_seen", {31'b0, out_valid}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("t3_hold_valid", {31'b0, out_valid}, 32'd1);
         chk("t3_hold_value", {26'b0, s, c_out, v}, {26'b0, 4'h0, 1'b1, 1'b0});
         chk("t3_hold_in_ready", {31'b0, in_ready}, 32'd0);
      end
      rdy_force = 1'b1;
      @(posedge clk);
      #1;
      chk("t3_out_valid_drop", {31'b0, out_valid}, 32'd0);
      chk("t3_in_ready_rise", {31'b0, in_ready}, 32'd1);

      // 4. carry-in and signed overflow
      send(4'd5, 4'd3, 1'b1, 1'b1, {4'h9, 1'b0, 1'b1});
      send(4'd8, 4'd8, 1'b0, 1'b1, {4'h0, 1'b1, 1'b1});

      // 5. in_valid during RUN ignored, then back-to-back
      send(4'd3, 4'd2, 1'b0, 1'b1, {4'h5, 1'b0, 1'b0});
      in_valid = 1'b1;
      a = 4'd2;
      b = 4'd2;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("t5_busy_in_ready", {31'b0, in_ready}, 32'd0);
      send(4'd1, 4'd1, 1'b0, 1'b1, {4'h2, 1'b0, 1'b0});
      send(4'd12, 4'd4, 1'b1, 1'b1, {4'h1, 1'b1, 1'b0});
      send(4'd9, 4'd10, 1'b0, 1'b1, {4'h3, 1'b1, 1'b1});
      wait_valid(n);
      @(posedge clk);
      #1;

      // 6. reset mid-RUN at cnt=2
      send(4'd9, 4'd9, 1'b0, 1'b0, 6'd0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_in_ready", {31'b0, in_ready}, 32'd1);
      chk("t6_out_valid", {31'b0, out_valid}, 32'd0);
      chk("t6_s", {28'b0, s}, 32'd0);
      chk("t6_c_out", {31'b0, c_out}, 32'd0);
      chk("t6_v", {31'b0, v}, 32'd0);
      #3 rst_n = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      chk("t6_no_valid_after_abort", {31'b0, seen}, 32'd0);
      send(4'd4, 4'd4, 1'b0, 1'b1, {4'h8, 1'b0, 1'b1});

      // Full operand sweep with random consumer readiness
      rdy_rand = 1'b1;
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            for (int k = 0; k < 2; k++) begin
               send(4'(i), 4'(j), 1'(k), 1'b1, model(4'(i), 4'(j), 1'(k)));
            end
         end
      end

      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
